// File: rtl/datapath_pkg.sv
// Shared types and constants for the self-sequencing datapath: opcodes, ALU
// functions, shift modes, sequencer states and status-bit positions.
package datapath_pkg;

  typedef enum logic [2:0] {
    OP_MOV_IMM = 3'b000,
    OP_MOV_REG = 3'b001,
    OP_ADD     = 3'b010,
    OP_CMP     = 3'b011,
    OP_AND     = 3'b100,
    OP_MVN     = 3'b101
  } op_e;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_NOTB} alu_op_e;

  typedef enum logic [1:0] {SH_NONE, SH_LSL1, SH_LSR1, SH_ASR1} shift_e;

  typedef enum logic [2:0] {S_IDLE, S_WIMM, S_RDA, S_RDB, S_EXEC, S_WB, S_DONE} state_e;

  localparam int STATUS_W = 3;
  localparam int STAT_Z   = 0;
  localparam int STAT_N   = 1;
  localparam int STAT_V   = 2;

  function automatic logic is_legal_op(input logic [2:0] op);
    return op <= OP_MVN;
  endfunction

  // First sequencer state after a command is accepted; illegal ops finish at once.
  function automatic state_e first_state(input logic [2:0] op);
    case (op)
      OP_MOV_IMM:                return S_WIMM;
      OP_MOV_REG, OP_MVN:        return S_RDB;
      OP_ADD, OP_CMP, OP_AND:    return S_RDA;
      default:                   return S_DONE;
    endcase
  endfunction

endpackage

// File: rtl/datapath_seq_if.sv
// Command/response bundle between an instruction source and datapath_seq,
// plus the debug register-file read port.
interface datapath_seq_if #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8
);
  import datapath_pkg::*;
  localparam int REG_AW = $clog2(NUM_REGS);

  logic                start;
  logic [2:0]          cmd_op;
  logic [REG_AW-1:0]   cmd_rd;
  logic [REG_AW-1:0]   cmd_rn;
  logic [REG_AW-1:0]   cmd_rm;
  logic [1:0]          cmd_shift;
  logic [DATA_W-1:0]   cmd_imm;
  logic                ready;
  logic                done;
  logic                err;
  logic [DATA_W-1:0]   result;
  logic [STATUS_W-1:0] status;
  logic [REG_AW-1:0]   dbg_addr;
  logic [DATA_W-1:0]   dbg_data;

  modport master (
    output start, cmd_op, cmd_rd, cmd_rn, cmd_rm, cmd_shift, cmd_imm, dbg_addr,
    input  ready, done, err, result, status, dbg_data
  );

  modport slave (
    input  start, cmd_op, cmd_rd, cmd_rn, cmd_rm, cmd_shift, cmd_imm, dbg_addr,
    output ready, done, err, result, status, dbg_data
  );
endinterface

// File: rtl/datapath_seq_regfile_n.sv
// NUM_REGS x DATA_W register file: one synchronous write port, combinational
// operand and debug read ports, asynchronous clear.
module regfile_n #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  localparam int REG_AW  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  logic [DATA_W-1:0] rd_vec [NUM_REGS];

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_entry
    localparam logic [REG_AW-1:0] IDX = REG_AW'(gi);
    logic [DATA_W-1:0] entry_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        entry_reg <= '0;
      end else if (we && waddr == IDX) begin
        entry_reg <= wdata;
      end
    end

    assign rd_vec[gi] = entry_reg;
  end

  assign rdata    = rd_vec[raddr];
  assign dbg_data = rd_vec[dbg_addr];
endmodule

// File: rtl/datapath_seq.sv
// Self-sequencing datapath: latches one command per start/ready handshake and
// walks it through register read, shift/ALU execute and write-back.
module datapath_seq
  import datapath_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  datapath_seq_if.slave bus
);
  localparam int REG_AW = $clog2(NUM_REGS);
  localparam int MSB    = DATA_W - 1;

  state_e              state_reg, state_next;
  logic [2:0]          op_reg;
  logic [REG_AW-1:0]   rd_reg, rn_reg, rm_reg;
  shift_e              shift_reg;
  logic [DATA_W-1:0]   imm_reg, a_reg, b_reg, c_reg;
  logic [STATUS_W-1:0] status_reg;

  logic                accept;
  logic                rf_we;
  logic [REG_AW-1:0]   rf_raddr;
  logic [DATA_W-1:0]   rf_rdata, rf_wdata;
  alu_op_e             alu_op;
  logic [DATA_W-1:0]   ain, b_sh, alu_res;
  logic                alu_v;

  assign bus.ready  = (state_reg == S_IDLE) || (state_reg == S_DONE);
  assign accept     = bus.start && bus.ready;
  assign bus.done   = (state_reg == S_DONE);
  assign bus.err    = bus.done && !is_legal_op(op_reg);
  assign bus.result = c_reg;
  assign bus.status = status_reg;

  // The single operand read port serves rn in RDA and rm in RDB.
  assign rf_raddr = (state_reg == S_RDA) ? rn_reg : rm_reg;
  assign rf_we    = (state_reg == S_WIMM) || (state_reg == S_WB);
  assign rf_wdata = (state_reg == S_WIMM) ? imm_reg : c_reg;

  regfile_n #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (rf_we),
    .waddr    (rd_reg),
    .wdata    (rf_wdata),
    .raddr    (rf_raddr),
    .rdata    (rf_rdata),
    .dbg_addr (bus.dbg_addr),
    .dbg_data (bus.dbg_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE: state_next = accept ? first_state(bus.cmd_op) : S_IDLE;
      S_WIMM:         state_next = S_DONE;
      S_RDA:          state_next = S_RDB;
      S_RDB:          state_next = S_EXEC;
      S_EXEC:         state_next = (op_reg == OP_CMP) ? S_DONE : S_WB;
      S_WB:           state_next = S_DONE;
      default:        state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg     <= '0;
      rd_reg     <= '0;
      rn_reg     <= '0;
      rm_reg     <= '0;
      shift_reg  <= SH_NONE;
      imm_reg    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      c_reg      <= '0;
      status_reg <= '0;
    end else begin
      if (accept) begin
        op_reg    <= bus.cmd_op;
        rd_reg    <= bus.cmd_rd;
        rn_reg    <= bus.cmd_rn;
        rm_reg    <= bus.cmd_rm;
        shift_reg <= shift_e'(bus.cmd_shift);
        imm_reg   <= bus.cmd_imm;
      end
      case (state_reg)
        S_WIMM: c_reg <= imm_reg;
        S_RDA:  a_reg <= rf_rdata;
        S_RDB:  b_reg <= rf_rdata;
        S_EXEC: begin
          c_reg              <= alu_res;
          status_reg[STAT_V] <= alu_v;
          status_reg[STAT_N] <= alu_res[MSB];
          status_reg[STAT_Z] <= (alu_res == '0);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    b_sh = b_reg;
    case (shift_reg)
      SH_LSL1: b_sh = {b_reg[MSB-1:0], 1'b0};
      SH_LSR1: b_sh = {1'b0, b_reg[MSB:1]};
      SH_ASR1: b_sh = {b_reg[MSB], b_reg[MSB:1]};
      default: ;
    endcase
  end

  // MOV_REG reuses the adder with a zero A operand, so its V flag is always 0.
  assign ain = (op_reg == OP_MOV_REG) ? '0 : a_reg;

  always_comb begin
    alu_op = ALU_ADD;
    case (op_reg)
      OP_CMP:  alu_op = ALU_SUB;
      OP_AND:  alu_op = ALU_AND;
      OP_MVN:  alu_op = ALU_NOTB;
      default: ;
    endcase
  end

  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        alu_res = ain + b_sh;
        alu_v   = (ain[MSB] == b_sh[MSB]) && (alu_res[MSB] != ain[MSB]);
      end
      ALU_SUB: begin
        alu_res = ain - b_sh;
        alu_v   = (ain[MSB] != b_sh[MSB]) && (alu_res[MSB] != ain[MSB]);
      end
      ALU_AND:  alu_res = ain & b_sh;
      ALU_NOTB: alu_res = ~b_sh;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_datapath_seq.sv
// Scoreboard bench for datapath_seq: stimulus pushes model results into a queue,
// a monitor pops and compares on every done pulse; small 8-bit instance too.
module tb_datapath_seq;
  import datapath_pkg::*;
  localparam int DW   = 16;
  localparam int NR   = 8;
  localparam int AW   = 3;
  localparam int MAXS = (1 << (DW - 1)) - 1;
  localparam int MINS = -(1 << (DW - 1));

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  datapath_seq_if #(.DATA_W(DW), .NUM_REGS(NR)) bus ();
  datapath_seq_if #(.DATA_W(8), .NUM_REGS(4)) bus8 ();

  datapath_seq #(.DATA_W(DW), .NUM_REGS(NR)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  datapath_seq #(.DATA_W(8), .NUM_REGS(4)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

  typedef struct {
    int            issue_cyc;
    int            lat;
    logic          err;
    logic [DW-1:0] result;
    logic [2:0]    status;
    logic [AW-1:0] rd;
    logic [DW-1:0] rd_val;
  } exp_t;

  exp_t          sb_q[$];
  int            vectors     = 0;
  int            miscompares = 0;
  logic [DW-1:0] m_rf [NR];
  logic [DW-1:0] m_c;
  logic [2:0]    m_st;
  logic          dbg_sel   = 1'b0;
  logic [AW-1:0] stim_addr = '0;
  logic [AW-1:0] mon_addr  = '0;
  assign bus.dbg_addr = dbg_sel ? stim_addr : mon_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sval(input logic [DW-1:0] x);
    return x[DW-1] ? int'(x) - (1 << DW) : int'(x);
  endfunction

  function automatic logic [DW-1:0] shift_ref(input logic [DW-1:0] b, input logic [1:0] sh);
    int v = int'(b);
    case (sh)
      2'd1:    v = v * 2;
      2'd2:    v = v / 2;
      2'd3:    v = v / 2 + (b[DW-1] ? (1 << (DW - 1)) : 0);
      default: ;
    endcase
    return DW'(v);
  endfunction

  function automatic logic [2:0] flags(input logic [DW-1:0] c, input logic v);
    return {v, c[DW-1], c == '0};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_rf[i] = '0;
    m_c  = '0;
    m_st = '0;
  endtask

  task automatic model_cmd(input logic [2:0] op, input logic [AW-1:0] rd, rn, rm,
                           input logic [1:0] sh, input logic [DW-1:0] imm, output exp_t e);
    int            sa, sb, s;
    logic [DW-1:0] bv;
    bv    = shift_ref(m_rf[rm], sh);
    sa    = (op == 3'd1) ? 0 : sval(m_rf[rn]);
    sb    = sval(bv);
    e.err = 1'b0;
    e.rd  = rd;
    case (op)
      3'd0: begin e.lat = 2; m_c = imm; m_rf[rd] = imm; end
      3'd1, 3'd2: begin
        e.lat = (op == 3'd1) ? 4 : 5;
        s = sa + sb; m_c = DW'(s); m_st = flags(m_c, s > MAXS || s < MINS); m_rf[rd] = m_c;
      end
      3'd3: begin
        e.lat = 4;
        s = sa - sb; m_c = DW'(s); m_st = flags(m_c, s > MAXS || s < MINS);
      end
      3'd4: begin e.lat = 5; m_c = m_rf[rn] & bv; m_st = flags(m_c, 1'b0); m_rf[rd] = m_c; end
      3'd5: begin e.lat = 4; m_c = ~bv; m_st = flags(m_c, 1'b0); m_rf[rd] = m_c; end
      default: begin e.lat = 1; e.err = 1'b1; end
    endcase
    e.result = m_c;
    e.status = m_st;
    e.rd_val = m_rf[rd];
  endtask

  task automatic issue(input logic [2:0] op, input logic [AW-1:0] rd, rn, rm,
                       input logic [1:0] sh, input logic [DW-1:0] imm);
    exp_t e;
    int   guard = 0;
    bus.cmd_op = op; bus.cmd_rd = rd; bus.cmd_rn = rn; bus.cmd_rm = rm;
    bus.cmd_shift = sh; bus.cmd_imm = imm; bus.start = 1'b1;
    @(negedge clk);
    while (!bus.ready && guard < 50) begin @(negedge clk); guard++; end
    if (!bus.ready) begin
      chk("accept_timeout", 32'(bus.ready), 32'd1);
    end else begin
      model_cmd(op, rd, rn, rm, sh, imm, e);
      e.issue_cyc = cyc;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (sb_q.size() != 0 && g < 100) begin @(posedge clk); g++; end
    if (sb_q.size() != 0) begin
      chk("drain_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Asserts reset away from clock edges and checks the cleared architectural state.
  task automatic reset_and_check();
    rst_n = 1'b0;
    sb_q.delete();
    model_reset();
    #2;
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_status", 32'(bus.status), 32'd0);
    dbg_sel = 1'b1;
    for (int i = 0; i < NR; i++) begin
      stim_addr = AW'(i);
      #1;
      chk("rst_regfile", 32'(bus.dbg_data), 32'd0);
    end
    dbg_sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run8(input logic [2:0] op, input logic [1:0] rd, rn, rm, input logic [7:0] imm,
                      input int lat, input logic [7:0] res, input logic [2:0] st, input logic er);
    int t0;
    int g = 0;
    bus8.cmd_op = op; bus8.cmd_rd = rd; bus8.cmd_rn = rn; bus8.cmd_rm = rm;
    bus8.cmd_shift = 2'd0; bus8.cmd_imm = imm; bus8.start = 1'b1;
    @(negedge clk);
    t0 = cyc;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    @(negedge clk);
    while (!bus8.done && g < 20) begin @(negedge clk); g++; end
    chk("d8_latency", 32'(cyc - t0), 32'(lat));
    chk("d8_result", 32'(bus8.result), 32'(res));
    chk("d8_status", 32'(bus8.status), 32'(st));
    chk("d8_err", 32'(bus8.err), 32'(er));
    $display("txn8 op=%0d rd=%0d result=0x%02h status=%03b", op, rd, bus8.result, bus8.status);
    @(posedge clk); #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.done) begin
        if (sb_q.size() == 0) begin
          chk("spurious_done", 32'(bus.done), 32'd0);
        end else begin
          e = sb_q.pop_front();
          mon_addr = e.rd;
          #1;
          chk("latency", 32'(cyc - e.issue_cyc), 32'(e.lat));
          chk("err", 32'(bus.err), 32'(e.err));
          chk("result", 32'(bus.result), 32'(e.result));
          chk("status", 32'(bus.status), 32'(e.status));
          chk("rd_value", 32'(bus.dbg_data), 32'(e.rd_val));
          $display("txn cycle=%0d rd=%0d result=0x%04h status=%03b err=%0b",
                   cyc, e.rd, bus.result, bus.status, bus.err);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic seen8;
    bus.start = 1'b0; bus.cmd_op = '0; bus.cmd_rd = '0; bus.cmd_rn = '0; bus.cmd_rm = '0;
    bus.cmd_shift = '0; bus.cmd_imm = '0;
    bus8.start = 1'b0; bus8.cmd_op = '0; bus8.cmd_rd = '0; bus8.cmd_rn = '0; bus8.cmd_rm = '0;
    bus8.cmd_shift = '0; bus8.cmd_imm = '0; bus8.dbg_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_and_check();

    issue(3'd0, 3, 0, 0, 2'd0, 16'h002A);
    drain();
    reset_and_check();

    issue(3'd0, 3, 0, 0, 2'd0, 16'h002A);
    issue(3'd0, 5, 0, 0, 2'd0, 16'h000D);
    issue(3'd2, 2, 3, 5, 2'd0, 16'h0000);
    // Now busy in RDA: this start (with altered fields) must be ignored.
    bus.cmd_op = 3'd0; bus.cmd_rd = 2; bus.cmd_imm = 16'hDEAD; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;

    issue(3'd0, 1, 0, 0, 2'd0, 16'h7FFF);
    issue(3'd0, 4, 0, 0, 2'd0, 16'h0001);
    issue(3'd2, 6, 1, 4, 2'd0, 16'h0000);
    issue(3'd3, 6, 4, 4, 2'd0, 16'h0000);
    issue(3'd0, 1, 0, 0, 2'd0, 16'h8003);
    issue(3'd1, 7, 0, 1, 2'd1, 16'h0000);
    issue(3'd1, 7, 0, 1, 2'd2, 16'h0000);
    issue(3'd1, 7, 0, 1, 2'd3, 16'h0000);
    issue(3'd5, 0, 0, 5, 2'd0, 16'h0000);
    issue(3'd2, 3, 1, 1, 2'd0, 16'h0000);
    issue(3'd6, 2, 0, 0, 2'd0, 16'hFFFF);
    issue(3'd7, 7, 1, 1, 2'd1, 16'h1234);
    issue(3'd2, 1, 1, 1, 2'd0, 16'h0000);
    drain();

    for (int i = 0; i < 200; i++) begin
      issue(3'($urandom_range(0, 7)), AW'($urandom_range(0, NR - 1)), AW'($urandom_range(0, NR - 1)),
            AW'($urandom_range(0, NR - 1)), 2'($urandom_range(0, 3)), DW'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    drain();

    // Abort an ADD in EXEC: nothing may complete and r2 must read back as zero.
    issue(3'd0, 2, 0, 0, 2'd0, 16'h1234);
    drain();
    issue(3'd2, 2, 3, 5, 2'd0, 16'h0000);
    @(posedge clk);
    @(posedge clk); #1;
    reset_and_check();
    repeat (8) @(posedge clk);
    #1;

    run8(3'd0, 2'd1, 2'd0, 2'd0, 8'h7F, 2, 8'h7F, 3'b000, 1'b0);
    run8(3'd0, 2'd2, 2'd0, 2'd0, 8'h01, 2, 8'h01, 3'b000, 1'b0);
    run8(3'd2, 2'd3, 2'd1, 2'd2, 8'h00, 5, 8'h80, 3'b110, 1'b0);
    bus8.dbg_addr = 2'd3;
    #1;
    chk("d8_r3", 32'(bus8.dbg_data), 32'h80);
    run8(3'd3, 2'd0, 2'd1, 2'd1, 8'h00, 4, 8'h00, 3'b001, 1'b0);
    run8(3'd6, 2'd3, 2'd0, 2'd0, 8'h55, 1, 8'h00, 3'b001, 1'b1);
    chk("d8_r3_kept", 32'(bus8.dbg_data), 32'h80);

    bus8.cmd_op = 3'd2; bus8.cmd_rd = 2'd3; bus8.cmd_rn = 2'd1; bus8.cmd_rm = 2'd2;
    bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    chk("d8_rst_ready", 32'(bus8.ready), 32'd1);
    chk("d8_rst_r3", 32'(bus8.dbg_data), 32'd0);
    chk("d8_rst_status", 32'(bus8.status), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen8 = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen8 = seen8 | bus8.done;
    end
    chk("d8_no_done", 32'(seen8), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/datapath_seq.md
Name: datapath_seq

Overview:
- Parametrised, self-sequencing successor to the lab datapath.
- Contains an NUM_REGS x DATA_W register file, A/B operand registers, shifter, ALU, C result register and Z/N/V status register.
- An internal FSM replaces externally driven loada/loadb/loadc/write/vsel strobes. It accepts one command per start/done handshake and steps the datapath through read, execute and write-back.
- Sits between a future instruction decoder and memory.

Parameters:
- DATA_W, 16, datapath word width (>=4).
- NUM_REGS, 8, register count (power of two, >=2); REG_AW = $clog2(NUM_REGS).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  command valid; accepted only when ready=1
- cmd_op  in  3  000 MOV_IMM, 001 MOV_REG, 010 ADD, 011 CMP, 100 AND, 101 MVN, 11x illegal
- cmd_rd / cmd_rn / cmd_rm  in  REG_AW each  destination / A-source / B-source
- cmd_shift  in  2  B-path shift: 00 none, 01 LSL1, 10 LSR1 (zero fill), 11 ASR1
- cmd_imm  in  DATA_W  immediate for MOV_IMM
- ready  out  1  high in IDLE and DONE
- done  out  1  one-cycle pulse at command completion
- err  out  1  high with done for an illegal op
- result  out  DATA_W  C register
- status  out  3  {V,N,Z}
- dbg_addr  in  REG_AW  debug read index
- dbg_data  out  DATA_W  combinational regfile[dbg_addr]

Behaviour:
- Reset (async, rst_n=0): state IDLE; all register-file entries, A, B, C, status and latched command cleared to 0; done=0, err=0; ready=1 once in IDLE.
- Accept: start=1 while ready=1 latches all cmd_* fields at the edge. Later changes to cmd_* are ignored. start while ready=0 is ignored, not queued.
- States: IDLE, WIMM, RDA, RDB, EXEC, WB, DONE.
  - WIMM: C<=cmd_imm; regfile[rd]<=cmd_imm.
  - RDA: A<=regfile[rn].
  - RDB: B<=regfile[rm].
  - EXEC: C<=ALU(Ain, shift(B)); status updated.
  - WB: regfile[rd]<=C.
  - DONE: done=1 for exactly one cycle, then IDLE. start accepted in DONE enables back-to-back commands.
- Paths by op (cycle 0 = accept cycle; done is high in cycle N):
  - MOV_IMM: WIMM, DONE; N=2; status unchanged.
  - MOV_REG: RDB, EXEC, WB, DONE; N=4; Ain forced 0, ALU ADD.
  - ADD and AND: RDA, RDB, EXEC, WB, DONE; N=5.
  - CMP: RDA, RDB, EXEC, DONE; N=4; ALU SUB; C and status updated, no register write.
  - MVN: RDB, EXEC, WB, DONE; N=4; C = ~shift(B).
  - Illegal: DONE directly; N=1; err=1 with done; no architectural state changes.
- Arithmetic: modulo 2^DATA_W.
  - Z = (C_next==0).
  - N = C_next[DATA_W-1].
  - V = signed overflow for ADD/SUB (MOV_REG's add counts); V=0 for AND/MVN.
  - Status loads only in EXEC.
- Shifts are by 1 bit and apply to the B operand only.
- Hazards: rd==rn==rm is legal. Reads complete before WB, so ADD r1,r1,r1 doubles r1.
- Reset asserted mid-command aborts it: no partial write survives, since all state is cleared.
- dbg_data reflects a write in the cycle after the WB/WIMM edge.

Decomposition:
- datapath_pkg: op_e, alu_op_e (ADD, SUB, AND, NOTB), shift_e, state_e enums; V/N/Z status bit index constants.
- Sub-module regfile_n (parameters DATA_W, NUM_REGS):
  - one synchronous write port;
  - two combinational read ports, one for operands and one for debug;
  - async active-low clear.
- Shifter and ALU stay as combinational blocks inside datapath_seq.

Test Plan:
- Reset then MOV_IMM rd=3 imm=0x002A: done in cycle 2, dbg_addr=3 gives 0x002A, result=0x002A, status=000. rst_n pulse afterwards clears dbg_data to 0.
- MOV_IMM r5=0x000D, then ADD rd=2 rn=3 rm=5 shift=00: done in cycle 5, r2=0x0037, status Z=0 N=0 V=0. start pulsed during busy is ignored (no second done).
- MOV_IMM r1=0x7FFF, r4=0x0001, then ADD rd=6 rn=1 rm=4: r6=0x8000, N=1 V=1. Then CMP rn=4 rm=4: done in cycle 4, Z=1, C=0, r6 unchanged.
- MOV_REG rd=7 rm=1 with shift 01/10/11, r1=0x8003: r7=0x0006 / 0x4001 / 0xC001. MVN rd=0 rm=5 shift=00 (r5=0x000D): r0=0xFFF2.
- Illegal op 110 issued back-to-back in the DONE cycle of a prior command: done and err both high one cycle later; all registers and status unchanged.
- Reset asserted in EXEC of ADD rd=2: immediate IDLE, r2=0, done never pulses. Repeat the block with DATA_W=8, NUM_REGS=4 to check the 0x7F+0x01 overflow case.
